// File: rtl/multi_channel_frequency_generator.sv
// Multi-channel tone-timing generator: one programmable period per channel,
// producing a one-cycle pulse and a 50%-duty square wave for each channel.
module multi_channel_frequency_generator #(
    parameter int CHANNELS        = 4,
    parameter int COUNT_WIDTH     = 28,
    parameter bit DEFERRED_UPDATE = 1'b1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   load,
    input  logic [3:0]             load_channel,
    input  logic [COUNT_WIDTH-1:0] load_period,
    input  logic                   sync,
    output logic [CHANNELS-1:0]    pulse,
    output logic [CHANNELS-1:0]    square,
    output logic [CHANNELS-1:0]    active
);

    logic [COUNT_WIDTH-1:0] period_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] period_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_q   [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_d   [CHANNELS];
    logic [COUNT_WIDTH-1:0] pending_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] pending_d [CHANNELS];
    logic [CHANNELS-1:0]    pending_valid_q;
    logic [CHANNELS-1:0]    pending_valid_d;
    logic [CHANNELS-1:0]    square_q;
    logic [CHANNELS-1:0]    square_d;

    always_comb begin
        pulse           = '0;
        active          = '0;
        pending_valid_d = pending_valid_q;
        square_d        = square_q;
        for (int c = 0; c < CHANNELS; c++) begin
            logic running;
            logic wrap;
            logic sel;

            period_d[c]  = period_q[c];
            count_d[c]   = count_q[c];
            pending_d[c] = pending_q[c];

            running   = (period_q[c] != '0);
            wrap      = running && (count_q[c] == '0) && !sync;
            sel       = load && (load_channel == 4'(c));
            pulse[c]  = wrap;
            active[c] = running;

            if (!running) begin
                count_d[c]  = '0;
                square_d[c] = 1'b0;
            end else if (wrap) begin
                // A wrap installs any pending period before a same-cycle load can replace it.
                if (DEFERRED_UPDATE && pending_valid_q[c]) begin
                    period_d[c]        = pending_q[c];
                    count_d[c]         = pending_q[c] - 1'b1;
                    pending_valid_d[c] = 1'b0;
                end else begin
                    count_d[c] = period_q[c] - 1'b1;
                end
                square_d[c] = ~square_q[c];
            end else if (count_q[c] != '0) begin
                count_d[c] = count_q[c] - 1'b1;
            end

            if (sel) begin
                if (load_period == '0) begin
                    period_d[c]        = '0;
                    count_d[c]         = '0;
                    square_d[c]        = 1'b0;
                    pending_valid_d[c] = 1'b0;
                end else if (!DEFERRED_UPDATE || !running) begin
                    period_d[c]        = load_period;
                    count_d[c]         = '0;
                    pending_valid_d[c] = 1'b0;
                end else begin
                    pending_d[c]       = load_period;
                    pending_valid_d[c] = 1'b1;
                end
            end

            // sync owns the phase: it overrides both wrap and load effects on count/square.
            if (sync) begin
                count_d[c]  = '0;
                square_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_q[c]  <= '0;
                count_q[c]   <= '0;
                pending_q[c] <= '0;
            end
            pending_valid_q <= '0;
            square_q        <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_q[c]  <= period_d[c];
                count_q[c]   <= count_d[c];
                pending_q[c] <= pending_d[c];
            end
            pending_valid_q <= pending_valid_d;
            square_q        <= square_d;
        end
    end

    assign square = square_q;

endmodule

// File: tb/tb_multi_channel_frequency_generator.sv
// Scoreboard bench for both update modes: a next-pulse-time model predicts
// pulse/square/active each cycle; a separate monitor compares DUT outputs.
module tb_multi_channel_frequency_generator;

    localparam int CH = 4;
    localparam int CW = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld  = 1'b0;
    logic          syn = 1'b0;
    logic [3:0]    lch = '0;
    logic [CW-1:0] lper = '0;
    logic [CH-1:0] pulse_i, square_i, active_i;
    logic [CH-1:0] pulse_d, square_d, active_d;

    always #5 clk = ~clk;

    multi_channel_frequency_generator #(
        .CHANNELS(CH), .COUNT_WIDTH(CW), .DEFERRED_UPDATE(1'b0)
    ) dut_imm (
        .CLOCK_50(clk), .reset(rst), .load(ld), .load_channel(lch),
        .load_period(lper), .sync(syn),
        .pulse(pulse_i), .square(square_i), .active(active_i)
    );

    multi_channel_frequency_generator #(
        .CHANNELS(CH), .COUNT_WIDTH(CW), .DEFERRED_UPDATE(1'b1)
    ) dut_def (
        .CLOCK_50(clk), .reset(rst), .load(ld), .load_channel(lch),
        .load_period(lper), .sync(syn),
        .pulse(pulse_d), .square(square_d), .active(active_d)
    );

    typedef struct packed {
        logic [1:0][CH-1:0] p;
        logic [1:0][CH-1:0] s;
        logic [1:0][CH-1:0] a;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: period, pending value and absolute cycle of the next pulse.
    int unsigned m_p    [2][CH];
    int unsigned m_pend [2][CH];
    bit          m_pv   [2][CH];
    bit          m_sq   [2][CH];
    longint      m_nt   [2][CH];
    longint      t      = 0;
    bit          armed  = 1'b0;

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, t, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit l, input int ch, input int per, input bit s);
        exp_t e;
        @(negedge clk);
        rst  = r;
        ld   = l;
        lch  = ch[3:0];
        lper = CW'(per);
        syn  = s;
        if (armed) begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++) begin
                    e.p[i][c] = (m_p[i][c] != 0) && (m_nt[i][c] == t) && !s;
                    e.s[i][c] = m_sq[i][c];
                    e.a[i][c] = (m_p[i][c] != 0);
                end
            q.push_back(e);
        end
        if (r) begin
            armed = 1'b1;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++) begin
                    m_p[i][c] = 0; m_pend[i][c] = 0; m_pv[i][c] = 0;
                    m_sq[i][c] = 0; m_nt[i][c] = 0;
                end
        end else if (armed) begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++) begin
                    bit run, fire;
                    run  = (m_p[i][c] != 0);
                    fire = run && (m_nt[i][c] == t) && !s;
                    if (fire) begin
                        m_sq[i][c] = !m_sq[i][c];
                        if (m_pv[i][c]) begin
                            m_p[i][c]  = m_pend[i][c];
                            m_pv[i][c] = 0;
                        end
                        m_nt[i][c] = t + m_p[i][c];
                    end
                    if (l && ch == c) begin
                        if (per == 0) begin
                            m_p[i][c] = 0; m_pv[i][c] = 0; m_sq[i][c] = 0;
                        end else if (i == 0 || !run) begin
                            m_p[i][c] = per; m_nt[i][c] = t + 1; m_pv[i][c] = 0;
                        end else begin
                            m_pend[i][c] = per; m_pv[i][c] = 1;
                        end
                    end
                    if (s) begin
                        m_nt[i][c] = t + 1;
                        m_sq[i][c] = 0;
                    end
                end
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imm_pulse",  pulse_i,  e.p[0]);
                chk("imm_square", square_i, e.s[0]);
                chk("imm_active", active_i, e.a[0]);
                chk("def_pulse",  pulse_d,  e.p[1]);
                chk("def_square", square_d, e.s[1]);
                chk("def_active", active_d, e.a[1]);
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0);
        step(1, 1, 2, 9, 1);
        idle(2);
        step(0, 1, 0, 4, 0);
        idle(12);
        step(0, 1, 1, 10, 0);
        idle(15);
        step(0, 1, 1, 3, 0);
        idle(25);
        step(0, 1, 2, 7, 0);
        idle(5);
        step(0, 1, 2, 0, 0);
        idle(4);
        step(0, 1, 2, 1, 0);
        idle(4);
        step(0, 1, 3, 6, 0);
        idle(3);
        step(0, 0, 0, 0, 1);
        idle(8);
        step(0, 1, 7, 5, 0);
        idle(3);
        step(0, 1, 0, 5, 1);
        idle(6);
        step(0, 1, 1, 9, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 3, (1 << CW) - 1, 0);
        idle(3);
        for (int k = 0; k < 3000; k++) begin
            bit r, l, s;
            int ch, per;
            r   = ($urandom_range(0, 199) == 0);
            l   = ($urandom_range(0, 3) == 0);
            ch  = $urandom_range(0, 7);
            per = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            s   = ($urandom_range(0, 29) == 0);
            step(r, l, ch, per, s);
        end
        idle(2);
        @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
